// File: rtl/dual_issue_scheduler.sv
// Dual-lane issue-pair scheduler between fetch and decode/extend.
// Issues an instruction pair (A older, B younger) together when independent;
// on a hazard it issues A alone, holds B, and issues B on lane A next advance.
module dual_issue_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid_i,
  input  logic [DATA_WIDTH-1:0] instrA_i,
  input  logic [DATA_WIDTH-1:0] instrB_i,
  output logic                  fetch_ready_o,
  input  logic                  issue_ready_i,
  input  logic                  flush_i,
  output logic                  issueA_valid_o,
  output logic                  issueB_valid_o,
  output logic [DATA_WIDTH-1:0] instrA_o,
  output logic [DATA_WIDTH-1:0] instrB_o,
  output logic [CNT_WIDTH-1:0]  split_cnt_o
);

  localparam logic [0:0] StPair  = 1'b0;
  localparam logic [0:0] StHoldB = 1'b1;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  logic [0:0]            state_q, state_d;
  logic                  va_q, va_d;
  logic                  vb_q, vb_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       adv;
  logic [6:0] op_a, op_b;
  logic [4:0] rd_a;
  logic       a_wr, b_wr, b_rs1, b_rs2;
  logic       raw, waw, mem, ctrl, conflict;

  function automatic logic op_writes(input logic [6:0] op);
    case (op)
      OpReg, OpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr: op_writes = 1'b1;
      default:                                             op_writes = 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rs1(input logic [6:0] op);
    case (op)
      OpReg, OpImm, OpLoad, OpStore, OpBranch, OpJalr: op_reads_rs1 = 1'b1;
      default:                                         op_reads_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    case (op)
      OpReg, OpStore, OpBranch: op_reads_rs2 = 1'b1;
      default:                  op_reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    op_is_mem = (op == OpLoad) || (op == OpStore);
  endfunction

  // Pair hazard decode on the incoming fetch pair.
  always_comb begin
    op_a     = instrA_i[6:0];
    op_b     = instrB_i[6:0];
    rd_a     = instrA_i[11:7];
    a_wr     = op_writes(op_a) && (rd_a != 5'd0);
    b_wr     = op_writes(op_b);
    b_rs1    = op_reads_rs1(op_b) && (instrB_i[19:15] == rd_a);
    b_rs2    = op_reads_rs2(op_b) && (instrB_i[24:20] == rd_a);
    raw      = a_wr && (b_rs1 || b_rs2);
    waw      = a_wr && b_wr && (instrB_i[11:7] == rd_a);
    mem      = op_is_mem(op_a) && op_is_mem(op_b);
    ctrl     = (op_a == OpBranch) || (op_a == OpJal) || (op_a == OpJalr);
    conflict = raw || waw || mem || ctrl;
  end

  // Handshake: the issue register may load when empty or being consumed.
  always_comb begin
    adv           = issue_ready_i || !(va_q || vb_q);
    fetch_ready_o = (state_q == StPair) && adv && !flush_i;
  end

  // Next-state: flush dominates, then advance, otherwise everything holds.
  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    vb_d    = vb_q;
    a_d     = a_q;
    b_d     = b_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      va_d    = 1'b0;
      vb_d    = 1'b0;
      state_d = StPair;
      hold_d  = '0;
    end else if (adv) begin
      if (state_q == StHoldB) begin
        // Held younger instruction always issues alone on lane A.
        a_d     = hold_q;
        va_d    = 1'b1;
        vb_d    = 1'b0;
        state_d = StPair;
      end else if (fetch_valid_i) begin
        a_d  = instrA_i;
        va_d = 1'b1;
        if (conflict) begin
          vb_d    = 1'b0;
          hold_d  = instrB_i;
          state_d = StHoldB;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end else begin
          b_d  = instrB_i;
          vb_d = 1'b1;
        end
      end else begin
        va_d = 1'b0;
        vb_d = 1'b0;
      end
    end
  end

  // Issue register, hold register, FSM state and split counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPair;
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    issueA_valid_o = va_q;
    issueB_valid_o = vb_q;
    instrA_o       = a_q;
    instrB_o       = b_q;
    split_cnt_o    = cnt_q;
  end

endmodule
